// File: rtl/sblock_cfg_loader.sv
// Serial configuration loader for a row of switch blocks.
// Shifts in one config word per block (MSB first), then pulses that block's
// latch enable for WR_HOLD cycles with the word on the shared bits bus,
// followed by one settle cycle for latch hold time.
// Optional feature: define SBLOCK_CFG_PARITY_EN for 19-bit words carrying a
// trailing even-parity bit; a bad word skips its write and sets sticky err.
module sblock_cfg_loader #(
  parameter int unsigned NUM_BLK = 16,
  parameter int unsigned WR_HOLD = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               s_valid,
  input  logic               s_data,
  output logic               s_ready,
  output logic [NUM_BLK-1:0] wr_en,
  output logic [17:0]        bits,
  output logic               busy,
  output logic               done,
  output logic               err
);

`ifdef SBLOCK_CFG_PARITY_EN
  localparam int unsigned WordW = 19;
`else
  localparam int unsigned WordW = 18;
`endif
  // Holds every bit of the word except the one arriving this cycle.
  localparam int unsigned SrW   = WordW - 1;
  localparam int unsigned IdxW  = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1;
  localparam int unsigned CntW  = 5;
  localparam int unsigned HoldW = $clog2(WR_HOLD + 1);

  typedef enum logic [2:0] {StIdle, StShift, StWrite, StSettle, StDone} state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [SrW-1:0]   sr_q, sr_d;
  logic [17:0]      bits_q, bits_d;
  logic [17:0]      word_data;
  logic             par_ok;

`ifdef SBLOCK_CFG_PARITY_EN
  logic             err_q, err_d;
  assign word_data = sr_q;
  assign par_ok    = ~^{sr_q, s_data};
  assign err       = err_q;
`else
  assign word_data = {sr_q, s_data};
  assign par_ok    = 1'b1;
  assign err       = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      sr_q    <= '0;
      bits_q  <= '0;
`ifdef SBLOCK_CFG_PARITY_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      sr_q    <= sr_d;
      bits_q  <= bits_d;
`ifdef SBLOCK_CFG_PARITY_EN
      err_q   <= err_d;
`endif
    end
  end

  // Next-state logic: shift, write, settle sequencing per block.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    sr_d    = sr_q;
    bits_d  = bits_q;
`ifdef SBLOCK_CFG_PARITY_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StShift;
          idx_d   = '0;
          cnt_d   = '0;
`ifdef SBLOCK_CFG_PARITY_EN
          err_d   = 1'b0;
`endif
        end
      end
      StShift: begin
        if (s_valid) begin
          sr_d  = {sr_q[SrW-2:0], s_data};
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(WordW - 1)) begin
            hold_d = '0;
            if (par_ok) begin
              state_d = StWrite;
              bits_d  = word_data;
            end else begin
              // Corrupt word: leave the block's latch untouched.
              state_d = StSettle;
`ifdef SBLOCK_CFG_PARITY_EN
              err_d   = 1'b1;
`endif
            end
          end
        end
      end
      StWrite: begin
        if (hold_q == HoldW'(WR_HOLD - 1)) begin
          state_d = StSettle;
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      StSettle: begin
        if (idx_q == IdxW'(NUM_BLK - 1)) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + IdxW'(1);
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded from registered state, so reset clears them immediately.
  always_comb begin
    s_ready = (state_q == StShift);
    busy    = (state_q == StShift) || (state_q == StWrite) || (state_q == StSettle);
    done    = (state_q == StDone);
    bits    = bits_q;
    wr_en   = '0;
    for (int unsigned i = 0; i < NUM_BLK; i++) begin
      wr_en[i] = (state_q == StWrite) && (idx_q == IdxW'(i));
    end
  end

endmodule

// File: tb/tb_sblock_cfg_loader.sv
// Scoreboard bench for sblock_cfg_loader (NUM_BLK=4, WR_HOLD=2).
module tb_sblock_cfg_loader;

  localparam int NB = 4;
  localparam int WH = 2;
`ifdef SBLOCK_CFG_PARITY_EN
  localparam int WORD_W = 19;
`else
  localparam int WORD_W = 18;
`endif

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          s_valid;
  logic          s_data;
  logic          s_ready;
  logic [NB-1:0] wr_en;
  logic [17:0]   bits;
  logic          busy;
  logic          done;
  logic          err;

  sblock_cfg_loader #(
    .NUM_BLK(NB),
    .WR_HOLD(WH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .s_valid(s_valid),
    .s_data (s_data),
    .s_ready(s_ready),
    .wr_en  (wr_en),
    .bits   (bits),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vec;
  int          mis;
  int          busy_cnt;
  int          done_cnt;
  int          stalls;
  int          attempt;
  logic [25:0] sb[$];  // {block index, expected bits}
  logic [17:0] words[NB];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected words on each wr_en pulse and checks bus behaviour.
  task automatic monitor();
    logic [NB-1:0] prev_wr;
    logic [17:0]   prev_bits;
    logic [25:0]   e;
    logic [NB-1:0] exp_wr;
    logic          pstart;
    int            plen;
    prev_wr   = '0;
    prev_bits = '0;
    plen      = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        prev_wr   = '0;
        prev_bits = '0;
        plen      = 0;
        continue;
      end
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      pstart = (wr_en != '0) && (prev_wr == '0);
      if (wr_en != '0) chk("wr_en_onehot", 32'($onehot(wr_en)), 32'd1);
      if (pstart) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", 32'(wr_en), 32'd0);
        end else begin
          e      = sb.pop_front();
          exp_wr = NB'(1) << e[25:18];
          chk("wr_en_sel", 32'(wr_en), 32'(exp_wr));
          chk("bits_value", 32'(bits), 32'(e[17:0]));
        end
        plen = 1;
      end else begin
        chk("bits_stable", 32'(bits), 32'(prev_bits));
        if (wr_en != '0) begin
          chk("wr_en_hold", 32'(wr_en), 32'(prev_wr));
          plen++;
        end else if (prev_wr != '0) begin
          chk("pulse_len", 32'(plen), 32'(WH));
        end
      end
      prev_wr   = wr_en;
      prev_bits = bits;
    end
  endtask

  // Feed one word; optionally assert start mid-word or reset during a write.
  task automatic stream_word(input logic [17:0] data, input int blk, input bit bad,
                             input bit stall_en, input int glitch_blk, input int rst_blk,
                             output bit aborted);
    logic [WORD_W-1:0] word;
    logic [NB-1:0]     rst_wr;
    int                i;
    int                guard;
`ifdef SBLOCK_CFG_PARITY_EN
    word = {data, bad ? ~(^data) : (^data)};
`else
    word = data;
`endif
    rst_wr  = NB'(1) << rst_blk;
    i       = WORD_W - 1;
    guard   = 0;
    aborted = 1'b0;
    while (i >= 0) begin
      @(negedge clk);
      guard++;
      if (guard > 300) begin
        chk("word_timeout", 32'd0, 32'd1);
        aborted = 1'b1;
        s_valid = 1'b0;
        return;
      end
      if (rst_blk >= 0 && wr_en == rst_wr) begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bits", 32'(bits), 32'd0);
        s_valid = 1'b0;
        start   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        aborted = 1'b1;
        return;
      end
      start = (blk == glitch_blk) && (i == 9);
      if (stall_en && ((attempt % 7 == 3) || (attempt % 11 == 5))) begin
        s_valid = 1'b0;
        if (s_ready) stalls++;
      end else begin
        s_valid = 1'b1;
        s_data  = word[i];
        if (s_ready) begin
          if (i == 0 && !bad) sb.push_back({8'(blk), data});
          i--;
        end
      end
      attempt++;
    end
  endtask

  task automatic run_load(input bit stall_en, input int glitch_blk, input int rst_blk,
                          input int bad_blk);
    int b0;
    int d0;
    int guard;
    int exp_busy;
    bit ab;
    stalls = 0;
    b0     = busy_cnt;
    d0     = done_cnt;
    @(negedge clk);
    start   = 1'b1;
    s_valid = 1'b0;
    for (int b = 0; b < NB; b++) begin
      stream_word(words[b], b, (b == bad_blk), stall_en, glitch_blk, rst_blk, ab);
      if (ab) return;
    end
    @(negedge clk);
    s_valid = 1'b0;
    start   = 1'b0;
    guard   = 0;
    while (!done && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("done_seen", 32'(done), 32'd1);
    chk("done_busy_low", 32'(busy), 32'd0);
    @(negedge clk);
    #1;
    exp_busy = NB * (WORD_W + WH + 1) + stalls - ((bad_blk >= 0) ? WH : 0);
    chk("busy_cycles", 32'(busy_cnt - b0), 32'(exp_busy));
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);
`ifdef SBLOCK_CFG_PARITY_EN
    chk("err_flag", 32'(err), 32'(bad_blk >= 0));
`else
    chk("err_flag", 32'(err), 32'd0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec      = 0;
    mis      = 0;
    busy_cnt = 0;
    done_cnt = 0;
    stalls   = 0;
    attempt  = 0;
    words[0] = 18'h3FFFF;
    words[1] = 18'h00000;
    words[2] = 18'h2AAAA;
    words[3] = 18'h15555;
    rst_n    = 1'b0;
    start    = 1'b0;
    s_valid  = 1'b0;
    s_data   = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", 32'({s_ready, wr_en, bits, busy, done, err}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_load(1'b0, -1, -1, -1);  // clean load
    run_load(1'b1, -1, -1, -1);  // stalls mid-word
    run_load(1'b0, 1, -1, -1);   // start during block 1 shift
    run_load(1'b0, -1, 2, -1);   // reset during block 2 write
    run_load(1'b0, -1, -1, -1);  // reload after abort
`ifdef SBLOCK_CFG_PARITY_EN
    run_load(1'b0, -1, -1, 1);   // bad parity on block 1
    @(negedge clk);
    #1;
    chk("err_sticky", 32'(err), 32'd1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule

// File: doc/sblock_cfg_loader.md
SBLOCK_CFG_LOADER -- requirements
Module: sblock_cfg_loader

Interface
REQ-001 SHALL have parameter NUM_BLK, default 16: number of switch blocks configured per load, legal range 2..64.
REQ-002 SHALL have parameter WR_HOLD, default 2: cycles wr_en is held high per block, legal range 1..8.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  begin a load; sampled only in IDLE.
REQ-007 SHALL have port s_valid  input  1  serial bitstream bit valid.
REQ-008 SHALL have port s_data  input  1  serial bitstream bit, MSB of each word first.
REQ-009 SHALL have port s_ready  output  1  loader accepts s_data this cycle.
REQ-010 SHALL have port wr_en  output  NUM_BLK  one-hot latch enable, one bit per switch block.
REQ-011 SHALL have port bits  output  18  shared config word: [17:9] horizontal dot controls, [8:0] vertical dot controls.
REQ-012 SHALL have port busy  output  1  high from start acceptance until done.
REQ-013 SHALL have port done  output  1  single-cycle pulse at end of load.
REQ-014 SHALL have port err  output  1  sticky parity error flag.

Function
REQ-015 SHALL implement states IDLE, SHIFT, WRITE, SETTLE, DONE.
REQ-016 IDLE: s_ready=0, wr_en=0; start=1 -> SHIFT next cycle, block index=0, bit count=0, err cleared.
REQ-017 SHIFT: s_ready=1; bit accepted when s_valid&&s_ready; accepted bit shifts into LSB of 18-bit shift register.
REQ-018 SHIFT: after last bit of a word accepted -> WRITE next cycle; bits loaded from shift register on that transition only.
REQ-019 WRITE: s_ready=0; wr_en[index]=1 for exactly WR_HOLD consecutive cycles, all other wr_en bits 0.
REQ-020 SETTLE: exactly one cycle, wr_en=0, bits unchanged (latch hold time).
REQ-021 SETTLE exit: index==NUM_BLK-1 -> DONE, else index+1 -> SHIFT with bit count=0.
REQ-022 DONE: done=1 for one cycle, busy=0 in the same cycle, -> IDLE.
REQ-023 bits SHALL change only on SHIFT->WRITE; stable through WRITE, SETTLE and until next word's WRITE.
REQ-024 wr_en SHALL never have more than one bit set; all zero outside WRITE.
REQ-025 start while busy SHALL be ignored; s_valid outside SHIFT SHALL be ignored with no bit consumed.
REQ-026 Stalls (s_valid=0) in SHIFT SHALL hold bit count and shift register indefinitely.

Reset
REQ-027 rst_n low SHALL force, asynchronously: state IDLE, wr_en=0, bits=0, s_ready=0, busy=0, done=0, err=0, counters 0.
REQ-028 Reset mid-load SHALL abort the load; blocks already written retain their latched values; next start restarts at index 0.

Configuration
REQ-029 Macro SBLOCK_CFG_PARITY_EN SHALL, when defined, make each word 19 bits: 18 data plus trailing even-parity bit over all 19.
REQ-030 With SBLOCK_CFG_PARITY_EN, a parity mismatch SHALL skip WRITE (no wr_en pulse, bits unchanged), set err, pass through SETTLE and advance index normally.
REQ-031 Without SBLOCK_CFG_PARITY_EN, words SHALL be 18 bits and err SHALL be tied 0.

Verification
REQ-032 NUM_BLK=4, WR_HOLD=2, start, stream words 0x3FFFF,0x00000,0x2AAAA,0x15555 no stalls -> wr_en=0001,0010,0100,1000 each 2 cycles with matching bits; done pulses once; total 4*(18+2+1)+2 cycles.
REQ-033 Random s_valid deasserts mid-word -> identical bits/wr_en sequence as REQ-032, delayed by stall count only.
REQ-034 start asserted during SHIFT of block 1 -> no restart, index continues to 2.
REQ-035 rst_n low during WRITE of block 2 -> wr_en=0 same cycle, busy=0; new start reloads from wr_en[0].
REQ-036 Parity enabled, word for block 1 with bad parity -> no wr_en[1] pulse, err=1 sticky, block 2 written normally, done pulses.
